// File: rtl/pcpi_div_arbiter.sv
// Two-port round-robin arbiter sharing one PCPI divider, with a hung-divider timeout.
// Optional feature macro: DIV_ARB_ZERO_BYPASS_EN (answer divide-by-zero locally).

module pcpi_div_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_insn,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    output logic        req0_wr,
    output logic [31:0] req0_rd,
    output logic        req0_wait,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_insn,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    output logic        req1_wr,
    output logic [31:0] req1_rd,
    output logic        req1_wait,
    output logic        req1_ready,
    output logic        div_valid,
    output logic [31:0] div_insn,
    output logic [31:0] div_rs1,
    output logic [31:0] div_rs2,
    input  logic        div_wr,
    input  logic [31:0] div_rd,
    input  logic        div_wait,
    input  logic        div_ready,
    output logic        err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_HOLDOFF} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    function automatic logic is_div(input logic valid, input logic [31:0] insn);
        return valid && (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && insn[14];
    endfunction

    state_t      r_state, w_nstate;
    logic        r_grant, w_ngrant, r_last;
    logic [15:0] r_cnt;
    logic [1:0]  r_wait, w_wait_nxt;
    logic        r_err;
    logic [31:0] r_insn, r_rs1, r_rs2, r_rd;
    logic        r_wr;
    logic [1:0]  w_elig;
    logic        w_any, w_win, w_bypass, w_limit;
    logic [31:0] w_win_insn, w_win_rs1, w_win_rs2, w_bypass_rd;
    logic        w_unused;

    assign w_unused    = div_wait;
    assign w_elig      = {is_div(req1_valid, req1_insn), is_div(req0_valid, req0_insn)};
    assign w_any       = |w_elig;
    assign w_win       = (&w_elig) ? ~r_last : w_elig[1];
    assign w_win_insn  = w_win ? req1_insn : req0_insn;
    assign w_win_rs1   = w_win ? req1_rs1 : req0_rs1;
    assign w_win_rs2   = w_win ? req1_rs2 : req0_rs2;
    assign w_limit     = (r_cnt == CNT_LAST);
    assign w_bypass_rd = w_win_insn[13] ? w_win_rs1 : 32'hFFFF_FFFF;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    assign w_bypass    = (w_win_rs2 == 32'd0);
`else
    assign w_bypass    = 1'b0;
`endif

    always_comb begin
        w_nstate = r_state;
        w_ngrant = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_ngrant = w_win;
                    w_nstate = w_bypass ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   if (div_ready || w_limit) w_nstate = S_RESP;
            S_RESP:    w_nstate = S_HOLDOFF;
            default:   w_nstate = S_IDLE;
        endcase
    end

    // The granted port waits while in flight; the just-served port's stale valid is ignored.
    always_comb begin
        w_wait_nxt = 2'b00;
        for (int n = 0; n < 2; n++) begin
            w_wait_nxt[n] = ((w_nstate == S_ISSUE) && (w_ngrant == n[0]))
                         || (w_elig[n]
                             && !((w_nstate == S_RESP) && (w_ngrant == n[0]))
                             && !(((r_state == S_RESP) || (r_state == S_HOLDOFF)) && (r_grant == n[0])));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_grant <= w_ngrant;
            r_wait  <= w_wait_nxt;
            r_err   <= (r_state == S_ISSUE) && !div_ready && w_limit;
            if (r_state == S_IDLE)
                r_cnt <= '0;
            else if ((r_state == S_ISSUE) && !div_ready && !w_limit)
                r_cnt <= r_cnt + 16'd1;
            if (r_state == S_RESP)
                r_last <= r_grant;
        end
    end

    // Request and result payload; outputs are gated by state, so no reset is needed here.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && w_any) begin
            r_insn <= w_win_insn;
            r_rs1  <= w_win_rs1;
            r_rs2  <= w_win_rs2;
            r_wr   <= w_bypass;
            r_rd   <= w_bypass_rd;
        end else if (r_state == S_ISSUE) begin
            if (div_ready) begin
                r_wr <= div_wr;
                r_rd <= div_rd;
            end else if (w_limit) begin
                r_wr <= 1'b0;
                r_rd <= '0;
            end
        end
    end

    assign div_valid   = (r_state == S_ISSUE);
    assign div_insn    = div_valid ? r_insn : '0;
    assign div_rs1     = div_valid ? r_rs1 : '0;
    assign div_rs2     = div_valid ? r_rs2 : '0;
    assign req0_ready  = (r_state == S_RESP) && !r_grant;
    assign req1_ready  = (r_state == S_RESP) && r_grant;
    assign req0_wr     = req0_ready & r_wr;
    assign req1_wr     = req1_ready & r_wr;
    assign req0_rd     = req0_ready ? r_rd : '0;
    assign req1_rd     = req1_ready ? r_rd : '0;
    assign req0_wait   = r_wait[0];
    assign req1_wait   = r_wait[1];
    assign err_timeout = r_err;

endmodule

// File: tb/tb_pcpi_div_arbiter.sv
// Self-checking bench for pcpi_div_arbiter: divider model plus per-port result scoreboard.

module tb_pcpi_div_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic [31:0] req0_insn = 0, req0_rs1 = 0, req0_rs2 = 0;
    logic [31:0] req1_insn = 0, req1_rs1 = 0, req1_rs2 = 0;
    logic        req0_wr, req0_wait, req0_ready, req1_wr, req1_wait, req1_ready;
    logic [31:0] req0_rd, req1_rd;
    logic        div_valid, err_timeout;
    logic [31:0] div_insn, div_rs1, div_rs2;
    logic        div_wr = 0, div_wait = 0, div_ready = 0;
    logic [31:0] div_rd = 0;

    pcpi_div_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_insn(req0_insn), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_wr(req0_wr), .req0_rd(req0_rd), .req0_wait(req0_wait), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_insn(req1_insn), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_wr(req1_wr), .req1_rd(req1_rd), .req1_wait(req1_wait), .req1_ready(req1_ready),
        .div_valid(div_valid), .div_insn(div_insn), .div_rs1(div_rs1), .div_rs2(div_rs2),
        .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int          order[$];
    logic [32:0] m_exp0, m_exp1;
    int          div_lat = 5;
    bit          div_hang = 0;
    int          div_cnt = 0;

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Reference RISC-V M-extension divide/remainder used by the divider model.
    function automatic logic [31:0] ref_div(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic ovf;
        sa = a;
        sb = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (insn[13:12])
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Divider model: completes div_lat cycles into each request unless hung.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            div_ready = 0;
            div_wr = 0;
            div_rd = 0;
            if (div_valid && !div_hang) begin
                div_cnt++;
                if (div_cnt >= div_lat) begin
                    div_ready = 1;
                    div_wr = 1;
                    div_rd = ref_div(div_insn, div_rs1, div_rs2);
                    div_cnt = 0;
                end
            end else begin
                div_cnt = 0;
            end
        end
    end

    // Result comparator: pops the per-port scoreboard on every ready pulse.
    always @(negedge clk) begin
        if (err_timeout) err_cnt++;
        checks++;
        if (req0_ready) begin
            order.push_back(0);
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL req0_unexpected_ready got wr=%b rd=%h, no request outstanding", req0_wr, req0_rd);
            end else begin
                m_exp0 = q0.pop_front();
                if ({req0_wr, req0_rd} !== m_exp0 || req0_wait !== 1'b0) begin
                    errors++;
                    $display("FAIL req0_result got wr=%b rd=%h wait=%b, expected wr=%b rd=%h wait=0",
                             req0_wr, req0_rd, req0_wait, m_exp0[32], m_exp0[31:0]);
                end
            end
        end else if ({req0_wr, req0_rd} !== 33'd0) begin
            errors++;
            $display("FAIL req0_quiet got wr=%b rd=%h without ready, expected 0", req0_wr, req0_rd);
        end
        checks++;
        if (req1_ready) begin
            order.push_back(1);
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL req1_unexpected_ready got wr=%b rd=%h, no request outstanding", req1_wr, req1_rd);
            end else begin
                m_exp1 = q1.pop_front();
                if ({req1_wr, req1_rd} !== m_exp1 || req1_wait !== 1'b0) begin
                    errors++;
                    $display("FAIL req1_result got wr=%b rd=%h wait=%b, expected wr=%b rd=%h wait=0",
                             req1_wr, req1_rd, req1_wait, m_exp1[32], m_exp1[31:0]);
                end
            end
        end else if ({req1_wr, req1_rd} !== 33'd0) begin
            errors++;
            $display("FAIL req1_quiet got wr=%b rd=%h without ready, expected 0", req1_wr, req1_rd);
        end
    end

    task automatic set_req(input int p, input logic v, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_insn = insn; req0_rs1 = a; req0_rs2 = b;
        end else begin
            req1_valid = v; req1_insn = insn; req1_rs1 = a; req1_rs2 = b;
        end
    endtask

    // One requester transaction: raise valid, hold until ready, drop on the following edge.
    task automatic drive(input int p, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input logic ewr, input logic [31:0] erd);
        bit seen;
        seen = 0;
        @(negedge clk);
        if (p == 0) q0.push_back({ewr, erd}); else q1.push_back({ewr, erd});
        set_req(p, 1'b1, insn, a, b);
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = (p == 0) ? req0_ready : req1_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ready_timeout port=%0d got no ready within 300 cycles, expected a ready pulse", p);
        end
        @(posedge clk);
        #1;
        set_req(p, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({div_valid, req0_ready, req0_wait, req0_wr, req1_ready, req1_wait, req1_wr, err_timeout} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b, expected 00000000",
                     {div_valid, req0_ready, req0_wait, req0_wr, req1_ready, req1_wait, req1_wr, err_timeout});
        end
        checks++;
        if ({div_insn, div_rs1, div_rs2, req0_rd, req1_rd} !== 160'd0) begin
            errors++;
            $display("FAIL reset_data got insn=%h rs1=%h rs2=%h rd0=%h rd1=%h, expected all 0",
                     div_insn, div_rs1, div_rs2, req0_rd, req1_rd);
        end
        reset = 0;
    endtask

    task automatic test_single();
        int n;
        bit prev_dr, seen, quiet_bad;
        n = 0; prev_dr = 0; seen = 0; quiet_bad = 0;
        fork
            drive(0, mk(3'b101), 32'd20, 32'd3, 1'b1, 32'd6);
            begin
                @(negedge clk);
                @(negedge clk);
                checks++;
                if (div_valid !== 1'b1 || div_rs1 !== 32'd20 || div_rs2 !== 32'd3 || div_insn !== mk(3'b101)) begin
                    errors++;
                    $display("FAIL single_issue got valid=%b rs1=%h rs2=%h insn=%h, expected 1/14/3/%h",
                             div_valid, div_rs1, div_rs2, div_insn, mk(3'b101));
                end
                checks++;
                if (req0_wait !== 1'b1) begin
                    errors++;
                    $display("FAIL single_wait got %b, expected 1", req0_wait);
                end
                n = 1;
                prev_dr = div_ready;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (req0_ready) begin seen = 1; break; end
                    if (div_valid) n++;
                    if (req1_ready || req1_wait) quiet_bad = 1;
                    prev_dr = div_ready;
                end
                checks++;
                if (!seen || n != 5 || prev_dr !== 1'b1 || div_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_timing got seen=%0d issue=%0d div_ready_before=%b div_valid=%b, expected 1/5/1/0",
                             seen, n, prev_dr, div_valid);
                end
                checks++;
                if (quiet_bad) begin
                    errors++;
                    $display("FAIL single_req1_quiet got req1 activity, expected none");
                end
            end
        join
    endtask

    task automatic test_dual();
        int bad;
        bit seen;
        logic w_at;
        bad = 0; seen = 0; w_at = 1'bx;
        do_reset();
        order.delete();
        fork
            drive(0, mk(3'b100), 32'hFFFF_FFEC, 32'd3, 1'b1, 32'hFFFF_FFFA);
            drive(1, mk(3'b110), 32'd20, 32'hFFFF_FFFD, 1'b1, 32'd2);
            begin
                @(negedge clk);
                @(negedge clk);
                for (int i = 0; i < 200; i++) begin
                    if (req1_ready) begin seen = 1; w_at = req1_wait; break; end
                    if (req1_wait !== 1'b1) bad++;
                    @(negedge clk);
                end
                checks++;
                if (!seen || bad != 0 || w_at !== 1'b0) begin
                    errors++;
                    $display("FAIL dual_req1_wait got seen=%0d low_cycles=%0d wait_at_ready=%b, expected 1/0/0",
                             seen, bad, w_at);
                end
            end
        join
        checks++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
            errors++;
            $display("FAIL dual_order got %p, expected '{0, 1}", order);
        end
    endtask

    task automatic test_back_to_back();
        order.delete();
        div_lat = 3;
        fork
            begin
                drive(0, mk(3'b101), 32'd100, 32'd9, 1'b1, 32'd11);
                drive(0, mk(3'b111), 32'd100, 32'd9, 1'b1, 32'd1);
            end
            drive(1, mk(3'b101), 32'd50, 32'd5, 1'b1, 32'd10);
        join
        checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
            errors++;
            $display("FAIL alternate_order got %p, expected '{0, 1, 0}", order);
        end
    endtask

    task automatic test_zero_div();
        int lat;
        bit dv_seen;
        lat = 0; dv_seen = 0;
        fork
            drive(1, mk(3'b110), 32'd20, 32'd0, 1'b1, 32'd20);
            begin
                @(negedge clk);
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    lat++;
                    if (div_valid) dv_seen = 1;
                    if (req1_ready) break;
                end
            end
        join
`ifdef DIV_ARB_ZERO_BYPASS_EN
        checks++;
        if (lat != 1 || dv_seen) begin
            errors++;
            $display("FAIL zero_bypass got latency=%0d div_valid_seen=%0d, expected 1/0", lat, dv_seen);
        end
`else
        checks++;
        if (!dv_seen) begin
            errors++;
            $display("FAIL zero_forward got div_valid_seen=%0d, expected 1", dv_seen);
        end
`endif
        drive(0, mk(3'b101), 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFF);
    endtask

    task automatic test_timeout();
        int bad, n, e0;
        logic err_at;
        bad = 0; n = 0; err_at = 1'bx;
        @(negedge clk);
        set_req(1, 1'b1, mk(3'b000), 32'd6, 32'd7);
        repeat (6) begin
            @(negedge clk);
            if (req1_wait || div_valid || req1_ready) bad++;
        end
        set_req(1, 1'b0, 32'd0, 32'd0, 32'd0);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mul_ignored got %0d active cycles, expected 0", bad);
        end
        div_hang = 1;
        e0 = err_cnt;
        fork
            drive(0, mk(3'b101), 32'd100, 32'd7, 1'b0, 32'd0);
            begin
                @(negedge clk);
                @(negedge clk);
                n = 1;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (req0_ready) begin err_at = err_timeout; break; end
                    if (div_valid) n++;
                end
            end
        join
        checks++;
        if (n != TO || err_at !== 1'b1 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL timeout got issue=%0d err_at_ready=%b pulses=%0d, expected %0d/1/1",
                     n, err_at, err_cnt - e0, TO);
        end
        div_hang = 0;
        drive(0, mk(3'b101), 32'd100, 32'd7, 1'b1, 32'd14);
        div_lat = TO;
        e0 = err_cnt;
        drive(1, mk(3'b101), 32'd99, 32'd10, 1'b1, 32'd9);
        checks++;
        if (err_cnt != e0) begin
            errors++;
            $display("FAIL ready_at_limit got %0d err pulses, expected 0", err_cnt - e0);
        end
        div_lat = 3;
    endtask

    task automatic test_reset_mid();
        div_hang = 1;
        @(negedge clk);
        set_req(0, 1'b1, mk(3'b101), 32'd40, 32'd4);
        repeat (3) @(negedge clk);
        checks++;
        if (div_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_issue got div_valid=%b, expected 1", div_valid);
        end
        reset = 1;
        set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if ({div_valid, req0_ready, req0_wait, req1_ready, req1_wait, err_timeout} !== 6'd0 || div_insn !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %b insn=%h, expected 000000 insn=0",
                     {div_valid, req0_ready, req0_wait, req1_ready, req1_wait, err_timeout}, div_insn);
        end
        reset = 0;
        div_hang = 0;
        drive(0, mk(3'b101), 32'd40, 32'd4, 1'b1, 32'd10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish by 500000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_zero_div();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got q0=%0d q1=%0d pending, expected 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
